// File: rtl/elevator_ctrl.sv
// SCAN (collective up/down) car sequencer: one floor per MOVE_CYCLES, door held DOOR_CYCLES,
// one-cycle clear pulses back to the request latch for every floor served.
module elevator_ctrl #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_W       = 3,
    parameter int MOVE_CYCLES   = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
    output logic [FLOOR_W-1:0]       floor,
    output logic                     direction,
    output logic                     moving,
    output logic                     door_open,
    output logic [BUTTONS_WIDTH-1:0] clr_in,
    output logic [BUTTONS_WIDTH-1:0] clr_up,
    output logic [BUTTONS_WIDTH-1:0] clr_down
);

    // state  | meaning
    // S_IDLE | car parked, choosing: open here, start up, start down, or wait
    // S_MOVE | travelling; stop test runs on the floor being arrived at
    // S_DOOR | door open for DOOR_CYCLES cycles
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

    typedef logic [BUTTONS_WIDTH-1:0] vec_t;

    function automatic logic bit_at(input vec_t v, input logic [FLOOR_W-1:0] f);
        bit_at = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++)
            if (i == int'(f)) bit_at = v[i];
    endfunction

    function automatic logic any_above(input vec_t v, input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++)
            if (i > int'(f) && v[i]) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input vec_t v, input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++)
            if (i < int'(f) && v[i]) any_below = 1'b1;
    endfunction

    function automatic vec_t onehot(input logic [FLOOR_W-1:0] f);
        onehot = '0;
        for (int i = 0; i < BUTTONS_WIDTH; i++)
            onehot[i] = (i == int'(f));
    endfunction

    state_t               state_q;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q, moving_q, door_q;
    vec_t                 clr_in_q, clr_up_q, clr_down_q;
    logic [CNT_W-1:0]     cnt_q;

    vec_t req, oh_f, oh_n;
    logic at_floor, above, below, above_n, below_n, stop_n, ahead_n;

    always_comb begin
        req      = active_in_levels | active_out_up_levels | active_out_down_levels;
        at_floor = bit_at(req, floor_q);
        above    = any_above(req, floor_q);
        below    = any_below(req, floor_q);
        floor_d  = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        above_n  = any_above(req, floor_d);
        below_n  = any_below(req, floor_d);
        oh_f     = onehot(floor_q);
        oh_n     = onehot(floor_d);
        // Hall calls against travel are only taken at the turnaround floor.
        stop_n   = bit_at(active_in_levels, floor_d)
                 | ( dir_q & bit_at(active_out_up_levels,   floor_d))
                 | (!dir_q & bit_at(active_out_down_levels, floor_d))
                 | ( dir_q & !above_n & bit_at(active_out_down_levels, floor_d))
                 | (!dir_q & !below_n & bit_at(active_out_up_levels,   floor_d));
        ahead_n  = dir_q ? above_n : below_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            clr_in_q   <= '0;
            clr_up_q   <= '0;
            clr_down_q <= '0;
            cnt_q      <= '0;
        end else begin
            clr_in_q   <= '0;
            clr_up_q   <= '0;
            clr_down_q <= '0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (at_floor) begin
                        state_q    <= S_DOOR;
                        door_q     <= 1'b1;
                        clr_in_q   <= oh_f;
                        clr_up_q   <= oh_f;
                        clr_down_q <= oh_f;
                    end else if (above && (dir_q || !below)) begin
                        dir_q    <= 1'b1;
                        state_q  <= S_MOVE;
                        moving_q <= 1'b1;
                    end else if (below) begin
                        dir_q    <= 1'b0;
                        state_q  <= S_MOVE;
                        moving_q <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (cnt_q == MOVE_LAST) begin
                        cnt_q   <= '0;
                        floor_q <= floor_d;
                        if (stop_n) begin
                            state_q    <= S_DOOR;
                            moving_q   <= 1'b0;
                            door_q     <= 1'b1;
                            clr_in_q   <= oh_n;
                            clr_up_q   <= (dir_q || !below_n) ? oh_n : '0;
                            clr_down_q <= (!dir_q || !above_n) ? oh_n : '0;
                        end else if (!ahead_n) begin
                            state_q  <= S_IDLE;
                            moving_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DOOR: begin
                    if (cnt_q == DOOR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        door_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign floor     = floor_q;
    assign direction = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign clr_in    = clr_in_q;
    assign clr_up    = clr_up_q;
    assign clr_down  = clr_down_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboarded bench for elevator_ctrl: a stop-level SCAN model predicts every door opening;
// a monitor pops and compares on each door_open rise.
module tb_elevator_ctrl;

    localparam int BW = 8;
    localparam int FW = 3;
    localparam int MC = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] lat_in = '0, lat_up = '0, lat_down = '0;
    logic [FW-1:0] floor;
    logic          direction, moving, door_open;
    logic [BW-1:0] clr_in, clr_up, clr_down;

    elevator_ctrl #(.BUTTONS_WIDTH(BW), .FLOOR_W(FW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clk                    (clk),
        .reset                  (rst_n),
        .active_in_levels       (lat_in),
        .active_out_up_levels   (lat_up),
        .active_out_down_levels (lat_down),
        .floor                  (floor),
        .direction              (direction),
        .moving                 (moving),
        .door_open              (door_open),
        .clr_in                 (clr_in),
        .clr_up                 (clr_up),
        .clr_down               (clr_down)
    );

    typedef struct {
        int         fl;
        logic [7:0] ci, cu, cd;
        logic       dir;
        int         cyc;
    } stop_t;

    stop_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    m_floor = 0;
    logic  m_dir   = 1'b1;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    // Request latch: served bits drop when the DUT pulses a clear.
    initial forever begin
        @(negedge clk);
        lat_in   = lat_in   & ~clr_in;
        lat_up   = lat_up   & ~clr_up;
        lat_down = lat_down & ~clr_down;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic any_gt(input logic [7:0] v, input int f);
        return (int'(v) >> (f + 1)) != 0;
    endfunction

    function automatic logic any_lt(input logic [7:0] v, input int f);
        return (int'(v) & ((1 << f) - 1)) != 0;
    endfunction

    // Stop-by-stop SCAN model over a request set that only shrinks as floors are served.
    task automatic model_batch(input logic [7:0] vi0, input logic [7:0] vu0, input logic [7:0] vd0,
                               input int t0, output int tend);
        logic [7:0] vi, vu, vd, req, bn;
        int   t, f, n, k;
        logic d, stop;
        stop_t s;
        vi = vi0; vu = vu0; vd = vd0;
        t = t0; f = m_floor; d = m_dir;
        for (int it = 0; it < 40; it++) begin
            req = vi | vu | vd;
            if (req == 0) break;
            if (req[f]) begin
                bn = 8'(1 << f);
                s.fl = f; s.ci = bn; s.cu = bn; s.cd = bn; s.dir = d; s.cyc = t + 1;
                exp_q.push_back(s);
                vi &= ~bn; vu &= ~bn; vd &= ~bn;
                t = t + 1 + DC;
                continue;
            end
            d = (any_gt(req, f) && (d || !any_lt(req, f))) ? 1'b1 : 1'b0;
            n = f; k = 0; stop = 1'b0;
            while (!stop && k < BW) begin
                n = d ? n + 1 : n - 1;
                k++;
                stop = vi[n] || (d && vu[n]) || (!d && vd[n])
                    || (d && !any_gt(req, n) && vd[n]) || (!d && !any_lt(req, n) && vu[n]);
            end
            bn = 8'(1 << n);
            s.fl  = n;
            s.ci  = bn;
            s.cu  = (d || !any_lt(req, n)) ? bn : 8'h00;
            s.cd  = (!d || !any_gt(req, n)) ? bn : 8'h00;
            s.dir = d;
            s.cyc = t + 1 + k * MC;
            exp_q.push_back(s);
            vi &= ~s.ci; vu &= ~s.cu; vd &= ~s.cd;
            f = n;
            t = s.cyc + DC;
        end
        m_floor = f;
        m_dir   = d;
        tend    = t;
    endtask

    // Monitor: every door opening is a DUT response checked against the scoreboard.
    initial begin
        logic  prev_door;
        int    door_len;
        stop_t e;
        prev_door = 1'b0;
        door_len  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_door = 1'b0;
                door_len  = 0;
            end else begin
                if (door_open && !prev_door) begin
                    if (exp_q.size() == 0) begin
                        chk("stop_unexpected_floor", int'(floor), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stop_floor", int'(floor), e.fl);
                        chk("stop_clr_in", int'(clr_in), int'(e.ci));
                        chk("stop_clr_up", int'(clr_up), int'(e.cu));
                        chk("stop_clr_down", int'(clr_down), int'(e.cd));
                        chk("stop_dir", int'(direction), int'(e.dir));
                        chk("stop_cycle", cyc, e.cyc);
                        chk("stop_not_moving", int'(moving), 0);
                    end
                end else begin
                    chk("clr_single_cycle", int'(clr_in | clr_up | clr_down), 0);
                end
                if (door_open) door_len++;
                if (!door_open && prev_door) begin
                    chk("door_len", door_len, DC);
                    door_len = 0;
                end
                prev_door = door_open;
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_batch(input logic [7:0] vi, input logic [7:0] vu, input logic [7:0] vd,
                               output int c0, output int tend);
        @(negedge clk);
        c0 = cyc;
        model_batch(vi, vu, vd, c0, tend);
        lat_in = lat_in | vi; lat_up = lat_up | vu; lat_down = lat_down | vd;
    endtask

    task automatic finish_batch(input int tend);
        wait_cyc(tend + 3);
        chk("stops_pending", exp_q.size(), 0);
        exp_q.delete();
        chk("end_floor", int'(floor), m_floor);
        chk("end_dir", int'(direction), int'(m_dir));
        chk("end_moving", int'(moving), 0);
        chk("end_door", int'(door_open), 0);
        chk("latch_drained", int'(lat_in | lat_up | lat_down), 0);
    endtask

    task automatic batch(input logic [7:0] vi, input logic [7:0] vu, input logic [7:0] vd);
        int c0, tend;
        start_batch(vi, vu, vd, c0, tend);
        finish_batch(tend);
    endtask

    initial begin
        int c0, tend, w;
        logic [7:0] ri, ru, rd;

        repeat (3) @(negedge clk);
        chk("rst_floor", int'(floor), 0);
        chk("rst_dir", int'(direction), 1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_clr", int'(clr_in | clr_up | clr_down), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Cabin call to floor 2 from floor 0 with exact step timing.
        start_batch(8'h04, 8'h00, 8'h00, c0, tend);
        wait_cyc(c0 + 1);  chk("s1_moving_c1", int'(moving), 1);
        wait_cyc(c0 + 4);  chk("s1_floor_c4", int'(floor), 0);
        wait_cyc(c0 + 5);  chk("s1_floor_c5", int'(floor), 1);
        wait_cyc(c0 + 9);  chk("s1_door_c9", int'(door_open), 1);
        wait_cyc(c0 + 11); chk("s1_door_c11", int'(door_open), 1);
        wait_cyc(c0 + 12); chk("s1_door_c12", int'(door_open), 0);
        finish_batch(tend);

        batch(8'h00, 8'h08, 8'h20);                 // up[3] then turnaround at down[5]
        batch(8'h40, 8'h00, 8'h00);
        batch(8'h10, 8'h00, 8'h00);                 // now at 4 travelling down
        chk("s3_dir_down", int'(direction), 0);
        batch(8'h42, 8'h00, 8'h00);                 // serves 1, reverses, serves 6
        batch(8'(1 << m_floor), 8'h00, 8'h00);      // request at current floor

        for (int i = 0; i < 40; i++) begin
            ri = 8'($urandom) & 8'($urandom) & 8'($urandom);
            ru = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'h7F;
            rd = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'hFE;
            if ($urandom_range(0, 3) == 0) ri[m_floor] = 1'b1;
            batch(ri, ru, rd);
        end

        // Withdrawn request: heading 5 -> 7, request dropped before reaching 6.
        batch(8'h20, 8'h00, 8'h00);
        @(negedge clk);
        c0 = cyc;
        lat_in = 8'h80;
        @(negedge clk);
        chk("s6_moving", int'(moving), 1);
        @(negedge clk);
        lat_in = 8'h00;
        wait_cyc(c0 + 8);
        chk("s6_floor", int'(floor), 6);
        chk("s6_moving_end", int'(moving), 0);
        chk("s6_door_end", int'(door_open), 0);
        m_floor = 6;
        m_dir   = 1'b1;

        // Asynchronous reset while passing floor 3 on the way down.
        @(negedge clk);
        lat_in = 8'h01;
        w = 0;
        while (!(floor == 3'd3 && moving) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("s5_reached_3", int'(floor == 3'd3 && moving), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_floor", int'(floor), 0);
        chk("s5_async_moving", int'(moving), 0);
        chk("s5_async_door", int'(door_open), 0);
        chk("s5_async_dir", int'(direction), 1);
        lat_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        m_floor = 0;
        m_dir   = 1'b1;
        @(negedge clk);
        batch(8'h00, 8'h00, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Sequencing controller for the elevator car. It consumes the latched request vectors produced by the `floors` request block and moves the car one floor at a time using a SCAN (collective up/down) policy. It times the door and issues one-cycle clear pulses so the request block can drop the requests it has served. It sits between the request latch and the motor/door drivers.

## Interface
- `BUTTONS_WIDTH`, 8: number of floors; one bit per floor in every vector. Range 2..2**FLOOR_W.
- `FLOOR_W`, 3: width of the floor index.
- `MOVE_CYCLES`, 16: clock cycles to travel one floor. Must be ≥1.
- `DOOR_CYCLES`, 32: clock cycles the door stays open per stop. Must be ≥1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `active_in_levels` input BUTTONS_WIDTH: cabin requests; bit f = floor f.
- `active_out_up_levels` input BUTTONS_WIDTH: hall "up" requests.
- `active_out_down_levels` input BUTTONS_WIDTH: hall "down" requests.
- `floor` output FLOOR_W: current car floor, registered.
- `direction` output 1: 1 = up, 0 = down. Registered.
- `moving` output 1: high while in MOVE.
- `door_open` output 1: high while in DOOR.
- `clr_in`, `clr_up`, `clr_down` output BUTTONS_WIDTH each: one-hot, single-cycle clear pulses for the served floor.

## Operation
- Derived terms, combinational on the current `floor` f:
  - `req = in | up | down`.
  - `above` = any `req` bit with index > f.
  - `below` = any `req` bit with index < f.
- States: IDLE, MOVE, DOOR.
- **IDLE**, evaluated in priority order:
  1. If `req[f]`: go to DOOR and pulse all three clears at bit f.
  2. Else if `above` and (`direction`=1 or !`below`): set `direction`=1 and go to MOVE.
  3. Else if `below`: set `direction`=0 and go to MOVE.
  4. Else stay in IDLE.
- **MOVE**: the travel counter counts 0..MOVE_CYCLES-1. On the terminal count:
  - `floor` becomes f±1 according to `direction`.
  - The stop test is evaluated on the new floor n, using the same-cycle inputs.
  - Stop if any of: `in[n]`; up-travelling and `up[n]`; down-travelling and `down[n]`; up-travelling with no request above n and `down[n]`; down-travelling with no request below n and `up[n]`.
  - On a stop: go to DOOR. Pulse `clr_in[n]`. Pulse `clr_up[n]` if travelling up or nothing is below n. Pulse `clr_down[n]` if travelling down or nothing is above n.
  - No stop, but a request exists beyond n in the current direction: stay in MOVE and restart the counter.
  - Otherwise (requests withdrawn): go to IDLE.
- **DOOR**: the door counter counts 0..DOOR_CYCLES-1, then the block goes to IDLE. IDLE re-evaluates, so a new request at the same floor reopens the door after one IDLE cycle.
- `direction` changes only in IDLE.
- `floor` never leaves 0..BUTTONS_WIDTH-1. Moves are only started or continued when a request exists in that direction, so there is no wrap-around.
- Request bits at index ≥ BUTTONS_WIDTH do not exist. All vectors are exactly BUTTONS_WIDTH wide.

## Timing
- Reset values, asynchronous on `reset`=0: state IDLE, `floor`=0, `direction`=1, `moving`=0, `door_open`=0, all clears 0, both counters 0.
- Reset asserted mid-move or mid-door returns to these values immediately. No position is retained.
- All outputs are registered. Clear pulses are asserted in the first DOOR cycle, together with `door_open` rising, and last exactly 1 cycle.
- `door_open` is high for exactly DOOR_CYCLES cycles per stop.
- IDLE decision latency is 1 cycle, from a request being visible to `moving` or `door_open` rising.
- Each floor step takes exactly MOVE_CYCLES cycles in MOVE. `floor` updates on the same edge that raises `door_open` on a stop.
- With the car at floor 0 and a request at floor k seen in IDLE at cycle 0: `floor`=k and `door_open`=1 at cycle 1+k·MOVE_CYCLES.
- Requests that arrive during DOOR are not cleared until a later stop or IDLE service.

## Test plan
All scenarios use MOVE_CYCLES=4, DOOR_CYCLES=3, BUTTONS_WIDTH=8.
1. Reset, then `active_in_levels`=8'b0000_0100 → `moving` high at cycle 1; `floor` steps 1 at cycle 5 and 2 at cycle 9; `door_open` high cycles 9–11; `clr_in`=8'h04 at cycle 9 only; IDLE at cycle 12.
2. Car at 0 with up[3] and down[5] → stops at 3 (clr_up=8'h08) → continues to 5 → clr_down=8'h20, clr_up=8'h20, `direction` still 1.
3. Car at 4, travelling down, with in[6] and in[1] → serves 1 first, then IDLE reverses `direction` to 1 and serves 6.
4. Request at the current floor in IDLE → no motion; `door_open` for 3 cycles; all clears pulse bit f.
5. Assert `reset`=0 asynchronously mid-MOVE (floor 3) → `floor`=0, `moving`=0, `door_open`=0 immediately, without waiting for a clock edge.
6. Request at 7 withdrawn while moving from 5 to 6 → at floor 6 there is no stop and nothing ahead → IDLE; `floor` stays 6.
